sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM controller command port between the CHR (PPU), PRG (CPU) and loader requesters.
//  Also schedules periodic auto-refresh.
//  Sits between the prg_ram/chr_ram front ends and the SDRAM controller; one transaction in flight at a time.
// PARAMETERS
//  ADDR_BITS          22   SDRAM word address width
//  DATA_BITS          16   SDRAM data width
//  REFRESH_INTERVAL   780  clk cycles between refresh requests
//  REFRESH_MAX_DEFER  64   cycles a due refresh may wait before it becomes urgent
// PORTS
//  clk                    in   1          system clock
//  reset                  in   1          synchronous, active-high reset
//  {chr,prg,ldr}_req      in   1          toggle request; pending while req != ack
//  {chr,prg,ldr}_ack      out  1          toggle ack; set equal to req on completion
//  {chr,prg,ldr}_we       in   1          1 = write, 0 = read
//  {chr,prg,ldr}_addr     in   ADDR_BITS  word address; stable while pending
//  {chr,prg,ldr}_wdata    in   DATA_BITS  write data; stable while pending
//  {chr,prg,ldr}_rdata    out  DATA_BITS  read data; valid once ack toggles, held until next read completes
//  mem_req                out  1          command valid (level)
//  mem_we                 out  1          command is write
//  mem_refresh            out  1          command is auto-refresh (addr/data ignored)
//  mem_addr               out  ADDR_BITS  command address
//  mem_wdata              out  DATA_BITS  command write data
//  mem_ready              in   1          command accepted this cycle (when mem_req=1)
//  mem_rvalid             in   1          read data strobe, 1 cycle
//  mem_rdata              in   DATA_BITS  read data
// BEHAVIOUR
//  Reset values
//   - All acks 0; all rdata 0.
//   - mem_req/we/refresh 0.
//   - FSM in IDLE; refresh counter 0; refresh_due 0; defer counter 0.
//  FSM: IDLE -> ISSUE -> (write: DONE | read: WAIT_RD -> DONE) -> IDLE; IDLE -> REFRESH -> IDLE.
//  IDLE
//   - Grant decided combinationally from pending flags.
//   - Priority: urgent refresh > CHR > PRG > refresh_due > LDR.
//   - On grant, latch channel id, addr, wdata and we into the mem_* registers.
//   - Next cycle, mem_req = 1 (registered outputs; 1 cycle grant latency).
//  ISSUE
//   - Hold mem_req and all mem_* stable until mem_ready = 1.
//   - Drop mem_req in the cycle after mem_ready.
//   - A write goes to DONE; a read goes to WAIT_RD.
//  WAIT_RD
//   - On mem_rvalid, capture mem_rdata into the granted channel's rdata.
//   - mem_rvalid in the same cycle as mem_ready is legal and skips WAIT_RD.
//  DONE
//   - Toggle the granted channel's ack (ack <= req), then return to IDLE.
//   - Request to ack: 1 + issue wait + read latency + 1 cycles minimum.
//  REFRESH
//   - mem_refresh = mem_req = 1 until mem_ready, then IDLE.
//   - Clears refresh_due and the defer counter.
//  Refresh counter
//   - Free-running 0..REFRESH_INTERVAL-1, wraps to 0.
//   - refresh_due is set at the wrap.
//   - Defer counter increments while refresh_due is set and saturates at REFRESH_MAX_DEFER.
//   - Urgent = defer counter == REFRESH_MAX_DEFER.
//   - A wrap while refresh_due is already set is not queued twice.
//  Other rules
//   - The in-flight transaction is never pre-empted; priority applies only in IDLE.
//   - A requester re-toggling req before ack is a protocol violation; the arbiter takes no action on it.
//   - Simultaneous CHR and PRG pending: CHR is served first, then PRG on the next IDLE.
//   - No starvation guard for LDR (loader runs only with the mapper held in reset).
//   - reset mid-transaction returns to IDLE and drops mem_req next cycle.
//     - The controller is also reset, so the lost command is acceptable.
//     - Acks clear to 0; requesters must clear req with the same reset.
// CONFIGURATION
//  SDRAM_ARB_LDR_EN
//   - Defined: loader channel present as above.
//   - Undefined: ldr_* ports remain, ldr_ack is tied 0, ldr_rdata is tied 0, and the LDR arm is removed from the grant logic.
// STRUCTURE
//  Package sdram_arb_pkg
//   - typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DONE, REFRESH} arb_state_t
//   - typedef enum logic [1:0] {CH_CHR, CH_PRG, CH_LDR} arb_ch_t
//  Sub-module sdram_refresh_timer: interval counter, defer counter, refresh_due, urgent; clear input from REFRESH.
// TESTING
//  - Single CHR read: chr_req toggles, addr 0x12345, mem_ready after 2 cycles, mem_rvalid with 0xBEEF 3 cycles later -> chr_rdata = 0xBEEF, then chr_ack toggles.
//  - CHR and PRG toggle in the same cycle -> CHR command issued first, PRG command issued on the next IDLE, acks toggle in that order.
//  - LDR write stream with CHR/PRG idle -> one mem_req per write, mem_we = 1, mem_wdata matches; with the macro undefined, ldr_ack stays 0.
//  - REFRESH_INTERVAL = 16, continuous PRG traffic -> refresh issued no later than 64 + 1 transaction after due; mem_refresh pulses once per interval.
//  - reset asserted during WAIT_RD -> mem_req 0 and acks 0 next cycle; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM command-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DONE, REFRESH} arb_state_t;
    typedef enum logic [1:0] {CH_CHR, CH_PRG, CH_LDR} arb_ch_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh scheduler: free-running interval counter, pending flag and
// defer counter that escalates a waiting refresh to urgent.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int INTERVAL  = 780,
    parameter int MAX_DEFER = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_due,
    output logic o_urgent
);

    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(INTERVAL - 1);
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_defer;
    logic          r_due;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_due   <= 1'b0;
            r_defer <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            // a wrap on the clearing cycle belongs to the next interval, so set wins
            if (w_wrap)
                r_due <= 1'b1;
            else if (i_clear)
                r_due <= 1'b0;
            if (i_clear)
                r_defer <= '0;
            else if (r_due && (r_defer != DEFER_MAX))
                r_defer <= r_defer + 1'b1;
        end
    end

    assign o_due    = r_due;
    assign o_urgent = (r_defer == DEFER_MAX);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command port between CHR, PRG and loader
// requesters, one transaction at a time, and inserts auto-refresh.
// Loader channel is present only when SDRAM_ARB_LDR_EN is defined.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_BITS         = 22,
    parameter int DATA_BITS         = 16,
    parameter int REFRESH_INTERVAL  = 780,
    parameter int REFRESH_MAX_DEFER = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_chr_req,
    output logic                 o_chr_ack,
    input  logic                 i_chr_we,
    input  logic [ADDR_BITS-1:0] i_chr_addr,
    input  logic [DATA_BITS-1:0] i_chr_wdata,
    output logic [DATA_BITS-1:0] o_chr_rdata,
    input  logic                 i_prg_req,
    output logic                 o_prg_ack,
    input  logic                 i_prg_we,
    input  logic [ADDR_BITS-1:0] i_prg_addr,
    input  logic [DATA_BITS-1:0] i_prg_wdata,
    output logic [DATA_BITS-1:0] o_prg_rdata,
    input  logic                 i_ldr_req,
    output logic                 o_ldr_ack,
    input  logic                 i_ldr_we,
    input  logic [ADDR_BITS-1:0] i_ldr_addr,
    input  logic [DATA_BITS-1:0] i_ldr_wdata,
    output logic [DATA_BITS-1:0] o_ldr_rdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_mem_refresh,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [DATA_BITS-1:0] o_mem_wdata,
    input  logic                 i_mem_ready,
    input  logic                 i_mem_rvalid,
    input  logic [DATA_BITS-1:0] i_mem_rdata
);

    arb_state_t r_state, w_next;
    arb_ch_t    r_ch, w_gnt_ch;

    logic                 r_mem_req, r_mem_we, r_mem_refresh;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [DATA_BITS-1:0] r_mem_wdata;
    logic                 r_chr_ack, r_prg_ack;
    logic [DATA_BITS-1:0] r_chr_rdata, r_prg_rdata;

    logic                 w_chr_pend, w_prg_pend, w_ldr_pend;
    logic                 w_gnt, w_gnt_ref;
    logic                 w_due, w_urgent, w_ref_clr;
    logic                 w_cap, w_ack_tgl;
    logic                 w_sel_we;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic [DATA_BITS-1:0] w_sel_wdata;

    sdram_refresh_timer #(
        .INTERVAL  (REFRESH_INTERVAL),
        .MAX_DEFER (REFRESH_MAX_DEFER)
    ) u_refresh (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_ref_clr),
        .o_due    (w_due),
        .o_urgent (w_urgent)
    );

    assign w_chr_pend = i_chr_req ^ r_chr_ack;
    assign w_prg_pend = i_prg_req ^ r_prg_ack;

`ifdef SDRAM_ARB_LDR_EN
    logic                 r_ldr_ack;
    logic [DATA_BITS-1:0] r_ldr_rdata;
    assign w_ldr_pend  = i_ldr_req ^ r_ldr_ack;
    assign o_ldr_ack   = r_ldr_ack;
    assign o_ldr_rdata = r_ldr_rdata;
`else
    logic w_ldr_unused;
    assign w_ldr_unused = ^{i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata};
    assign w_ldr_pend   = 1'b0;
    assign o_ldr_ack    = 1'b0;
    assign o_ldr_rdata  = '0;
`endif

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_ref = 1'b0;
        w_gnt_ch  = CH_CHR;
        if (w_urgent)
            w_gnt_ref = 1'b1;
        else if (w_chr_pend)
            w_gnt = 1'b1;
        else if (w_prg_pend) begin
            w_gnt    = 1'b1;
            w_gnt_ch = CH_PRG;
        end else if (w_due)
            w_gnt_ref = 1'b1;
        else if (w_ldr_pend) begin
            w_gnt    = 1'b1;
            w_gnt_ch = CH_LDR;
        end
    end

    always_comb begin
        w_sel_we    = i_chr_we;
        w_sel_addr  = i_chr_addr;
        w_sel_wdata = i_chr_wdata;
        case (w_gnt_ch)
            CH_PRG: begin
                w_sel_we    = i_prg_we;
                w_sel_addr  = i_prg_addr;
                w_sel_wdata = i_prg_wdata;
            end
`ifdef SDRAM_ARB_LDR_EN
            CH_LDR: begin
                w_sel_we    = i_ldr_we;
                w_sel_addr  = i_ldr_addr;
                w_sel_wdata = i_ldr_wdata;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_ref) w_next = REFRESH;
                     else if (w_gnt) w_next = ISSUE;
            ISSUE:   if (i_mem_ready)
                         w_next = (r_mem_we || i_mem_rvalid) ? DONE : WAIT_RD;
            WAIT_RD: if (i_mem_rvalid) w_next = DONE;
            DONE:    w_next = IDLE;
            REFRESH: if (i_mem_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // read data may arrive together with the command accept
    assign w_cap     = ((r_state == ISSUE) && i_mem_ready && !r_mem_we && i_mem_rvalid) ||
                       ((r_state == WAIT_RD) && i_mem_rvalid);
    assign w_ack_tgl = (r_state == DONE);
    assign w_ref_clr = (r_state == REFRESH) && i_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_refresh <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_ch          <= CH_CHR;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_ref) begin
                        r_mem_req     <= 1'b1;
                        r_mem_refresh <= 1'b1;
                        r_mem_we      <= 1'b0;
                    end else if (w_gnt) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_ch        <= w_gnt_ch;
                    end
                end
                ISSUE, REFRESH: begin
                    if (i_mem_ready) begin
                        r_mem_req     <= 1'b0;
                        r_mem_refresh <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chr_ack   <= 1'b0;
            r_prg_ack   <= 1'b0;
            r_chr_rdata <= '0;
            r_prg_rdata <= '0;
`ifdef SDRAM_ARB_LDR_EN
            r_ldr_ack   <= 1'b0;
            r_ldr_rdata <= '0;
`endif
        end else begin
            if (w_cap) begin
                case (r_ch)
                    CH_CHR:  r_chr_rdata <= i_mem_rdata;
                    CH_PRG:  r_prg_rdata <= i_mem_rdata;
`ifdef SDRAM_ARB_LDR_EN
                    CH_LDR:  r_ldr_rdata <= i_mem_rdata;
`endif
                    default: ;
                endcase
            end
            if (w_ack_tgl) begin
                case (r_ch)
                    CH_CHR:  r_chr_ack <= i_chr_req;
                    CH_PRG:  r_prg_ack <= i_prg_req;
`ifdef SDRAM_ARB_LDR_EN
                    CH_LDR:  r_ldr_ack <= i_ldr_req;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_chr_ack     = r_chr_ack;
    assign o_prg_ack     = r_prg_ack;
    assign o_chr_rdata   = r_chr_rdata;
    assign o_prg_rdata   = r_prg_rdata;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_refresh = r_mem_refresh;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;

endmodule
